// File: rtl/reorder_resize_div_pkg.sv
// Shared types, widths and saturation helper for the resize-path sequential divider.
// The saturate helper works on the package default widths (QUOT_W, WIDE_W).
package reorder_resize_div_pkg;

  localparam int DIVIDEND_W = 28;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 20;
  localparam int WIDE_W     = QUOT_W + 8;

  localparam logic signed [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  // Same bounds sign-extended to the wide pre-saturation width.
  localparam logic signed [WIDE_W-1:0] WIDE_MAX = {{(WIDE_W-QUOT_W+1){1'b0}}, {(QUOT_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] WIDE_MIN = {{(WIDE_W-QUOT_W+1){1'b1}}, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [QUOT_W-1:0] value;
    logic                     clamped;
  } sat_t;

  function automatic sat_t saturate(input logic signed [WIDE_W-1:0] v);
    sat_t r;
    if (v > WIDE_MAX) begin
      r.value   = QUOT_MAX;
      r.clamped = 1'b1;
    end else if (v < WIDE_MIN) begin
      r.value   = QUOT_MIN;
      r.clamped = 1'b1;
    end else begin
      r.value   = QUOT_W'(v);
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_resize_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
module reorder_resize_div_step #(
  parameter int DIVISOR_WIDTH = 8
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH-1:0] rem_o,
  output logic                     q_bit_o
);

  // One extra bit so the shifted remainder cannot overflow before the compare.
  logic [DIVISOR_WIDTH:0] partial;

  always_comb begin
    partial = {rem_i, bit_i};
    q_bit_o = (partial >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? DIVISOR_WIDTH'(partial - {1'b0, divisor_i})
                      : DIVISOR_WIDTH'(partial);
  end

endmodule

// File: rtl/reorder_resize_div_seq.sv
// Sequential signed-by-unsigned radix-2 restoring divider with saturating quotient.
// Define REORDER_RESIZE_DIV_ROUND_EN to round half away from zero instead of truncating.
module reorder_resize_div_seq
  import reorder_resize_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOT_WIDTH     = QUOT_W
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic        [DIVISOR_WIDTH-1:0]  divisor,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [QUOT_WIDTH-1:0]     quotient,
  output logic signed [DIVISOR_WIDTH:0]    remainder,
  output logic                            div_by_zero,
  output logic                            sat
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  state_t                            state_q, state_d;
  logic        [CNT_W-1:0]           count_q, count_d;
  logic        [DIVIDEND_WIDTH-1:0]  mag_q, mag_d;
  logic        [DIVISOR_WIDTH-1:0]   rem_q, rem_d;
  logic        [DIVISOR_WIDTH-1:0]   divisor_q, divisor_d;
  logic                              neg_q, neg_d;
  logic signed [QUOT_WIDTH-1:0]      quot_q, quot_d;
  logic signed [DIVISOR_WIDTH:0]     remn_q, remn_d;
  logic                              dbz_q, dbz_d;
  logic                              sat_q, sat_d;

  logic        [DIVISOR_WIDTH-1:0]   step_rem;
  logic                              step_bit;
  logic        [WIDE_W-1:0]          qmag_w;
  logic signed [WIDE_W-1:0]          q_signed;
  logic signed [DIVISOR_WIDTH:0]     rem_mag;
  logic signed [DIVISOR_WIDTH:0]     rem_signed;
  sat_t                              sat_r;

  // mag_q shifts left each step: dividend bits leave the top, quotient bits enter the bottom.
  reorder_resize_div_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (mag_q[DIVIDEND_WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    qmag_w  = WIDE_W'(mag_q);
    rem_mag = {1'b0, rem_q};
`ifdef REORDER_RESIZE_DIV_ROUND_EN
    if ({rem_q, 1'b0} >= {1'b0, divisor_q}) begin
      qmag_w  = qmag_w + WIDE_W'(1);
      rem_mag = rem_mag - $signed({1'b0, divisor_q});
    end
`endif
    q_signed   = neg_q ? -$signed(qmag_w) : $signed(qmag_w);
    rem_signed = neg_q ? -rem_mag : rem_mag;
    sat_r      = saturate(q_signed);
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
    state_d   = state_q;
    count_d   = count_q;
    mag_d     = mag_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    neg_d     = neg_q;
    quot_d    = quot_q;
    remn_d    = remn_q;
    dbz_d     = dbz_q;
    sat_d     = sat_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Magnitude is kept unsigned so the most negative dividend stays exact.
          mag_d     = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
          divisor_d = divisor;
          neg_d     = dividend[DIVIDEND_WIDTH-1];
          rem_d     = '0;
          count_d   = CNT_W'(DIVIDEND_WIDTH);
          dbz_d     = (divisor == '0);
          state_d   = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        mag_d   = {mag_q[DIVIDEND_WIDTH-2:0], step_bit};
        rem_d   = step_rem;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_q) begin
          quot_d = neg_q ? QUOT_MIN : QUOT_MAX;
          remn_d = '0;
          sat_d  = 1'b0;
        end else begin
          quot_d = sat_r.value;
          remn_d = rem_signed;
          sat_d  = sat_r.clamped;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mag_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      quot_q    <= '0;
      remn_q    <= '0;
      dbz_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      neg_q     <= neg_d;
      quot_q    <= quot_d;
      remn_q    <= remn_d;
      dbz_q     <= dbz_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remn_q;
  assign div_by_zero = dbz_q;
  assign sat         = sat_q;

endmodule
